// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry and dump-engine state encoding
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SEND_A = 3'd2;
  localparam logic [2:0] ST_SEND_B = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    FETCH = ST_FETCH,
    SEND_A = ST_SEND_A,
    SEND_B = ST_SEND_B,
    DONE = ST_DONE
  } dump_state_e;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: valid/ready word stream tagged with register index and last flag
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic valid;
  logic ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] index;
  logic last;
  modport master (output valid, data, index, last, input ready);
  modport slave (input valid, data, index, last, output ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks the register file two registers at a time and streams each value out
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] dump_rs1,
  output logic [ADDR_W-1:0] dump_rs2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  regfile_dump_reader_if.master out,
  output logic              busy,
  output logic              done
);
  dump_state_e state_q, state_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DATA_W-1:0] buf_a_q, buf_a_d, buf_b_q, buf_b_d;
  logic last;
  // rs1_q doubles as the pair pointer; rs2_q is always rs1_q+1
  assign last = rs2_q == ADDR_W'(NUM_REGS - 1);
  always_comb begin
    state_d = state_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        rs1_d = '0;
        rs2_d = ADDR_W'(1);
      end
      FETCH: begin
        state_d = SEND_A;
        buf_a_d = read_data1;
        buf_b_d = read_data2;
      end
      SEND_A: state_d = out.ready ? SEND_B : SEND_A;
      SEND_B: if (out.ready) begin
        state_d = last ? DONE : FETCH;
        rs1_d = last ? rs1_q : rs1_q + ADDR_W'(2);
        rs2_d = last ? rs2_q : rs2_q + ADDR_W'(2);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rs1_q <= '0;
      rs2_q <= '0;
      buf_a_q <= '0;
      buf_b_q <= '0;
    end else begin
      state_q <= state_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
    end
  end
  assign dump_rs1 = rs1_q;
  assign dump_rs2 = rs2_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign out.valid = state_q == SEND_A || state_q == SEND_B;
  assign out.data = state_q == SEND_A ? buf_a_q : state_q == SEND_B ? buf_b_q : '0;
  assign out.index = state_q == SEND_A ? rs1_q : state_q == SEND_B ? rs2_q : '0;
  assign out.last = state_q == SEND_B && last;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed checks of the dump engine against a register-file model
module tb_regfile_dump_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic we = 1'b0;
  logic rf_clr = 1'b1;
  logic [4:0] rs1, rs2;
  logic [4:0] wa = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd1, rd2;
  logic busy, done;
  logic [31:0] rf [32];
  logic [31:0] exp_rf [32];
  int passed = 0;
  int fails = 0;
  int total = 0;
  regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) ob ();
  regfile_dump_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .dump_rs1(rs1), .dump_rs2(rs2),
    .read_data1(rd1), .read_data2(rd2),
    .out(ob), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rf_clr) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (we) rf[wa] <= wd;
  end
  assign rd1 = rf[rs1];
  assign rd2 = rf[rs2];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic dump(input bit bp, input bit restart, input bit snp, output int nw, output int dc);
    int cyc, ndone;
    bit held;
    logic [63:0] hv;
    nw = 0; dc = 0; ndone = 0; held = 0; cyc = 0; hv = '0;
    @(negedge clk);
    start = 1'b1;
    ob.ready = 1'b1;
    while (ndone == 0 && cyc < 400) begin
      @(negedge clk);
      start = 1'b0;
      we = 1'b0;
      cyc++;
      if (cyc == 1) chk("fetch_addr", 64'({busy, ob.valid, rs1, rs2}), 64'({1'b1, 1'b0, 5'd0, 5'd1}));
      if (held && ob.valid) chk("stall_stable", {ob.data, 26'b0, ob.index, ob.last}, hv);
      if (done) begin ndone++; dc = cyc; end
      ob.ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (restart && nw == 10 && ob.valid) start = 1'b1;
      if (snp && busy && !ob.valid && rs1 == 5'd4) begin we = 1'b1; wa = 5'd5; wd = 32'h12345678; end
      held = ob.valid && !ob.ready;
      hv = {ob.data, 26'b0, ob.index, ob.last};
      if (ob.valid && ob.ready) begin
        chk("word_index", 64'(ob.index), 64'(nw));
        chk("word_data", 64'(ob.data), 64'(exp_rf[nw[4:0]]));
        chk("word_last", 64'(ob.last), 64'(nw == 31));
        nw++;
      end
    end
    we = 1'b0;
    chk("done_seen", 64'(ndone), 64'd1);
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
      chk("idle_after_done", 64'({busy, done}), 64'd0);
    end
  endtask
  initial begin
    int nw, dc, cyc;
    ob.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'({ob.valid, ob.last, busy, done, rs1, rs2, ob.index, ob.data}), 64'd0);
    rst = 1'b0;
    rf_clr = 1'b0;
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    @(negedge clk);
    chk("idle_after_rst", 64'({busy, ob.valid, done}), 64'd0);
    we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5;
    @(negedge clk);
    we = 1'b0;
    exp_rf[3] = 32'hA5A5A5A5;
    dump(1'b0, 1'b0, 1'b0, nw, dc);
    chk("basic_count", 64'(nw), 64'd32);
    chk("basic_done_cyc", 64'(dc), 64'd49);
    dump(1'b1, 1'b0, 1'b0, nw, dc);
    chk("bp_count", 64'(nw), 64'd32);
    dump(1'b0, 1'b1, 1'b0, nw, dc);
    chk("restart_count", 64'(nw), 64'd32);
    chk("restart_done_cyc", 64'(dc), 64'd49);
    @(negedge clk);
    start = 1'b1;
    ob.ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(ob.valid && ob.index == 5'd7) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_idx7", 64'({ob.valid, ob.index}), 64'({1'b1, 5'd7}));
    #2 rst = 1'b1;
    #1 chk("async_rst", 64'({ob.valid, busy, done, rs1, rs2, ob.index, ob.data}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_done_after_rst", 64'({busy, done}), 64'd0);
    end
    dump(1'b0, 1'b0, 1'b0, nw, dc);
    chk("after_rst_count", 64'(nw), 64'd32);
    dump(1'b0, 1'b0, 1'b1, nw, dc);
    chk("snap_count", 64'(nw), 64'd32);
    exp_rf[5] = 32'h12345678;
    dump(1'b0, 1'b0, 1'b0, nw, dc);
    chk("second_count", 64'(nw), 64'd32);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
